mem_access_unit: RTL and testbench

Load/store front end that sits directly upstream of the word-addressed data memory. It accepts RISC-V byte-addressed load and store requests (B/H/W, signed and unsigned) over a valid/ready handshake and translates them into word accesses on the memory port. Sub-word stores are done as read-modify-write; load data is lane-extracted and extended. Misaligned, illegal and out-of-range requests return an error response without touching memory.

---
 rtl/mem_access_unit_if.sv | 23 ++
 rtl/mem_access_unit.sv | 154 +++++++++++++++
 tb/tb_mem_access_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response channel between a load/store client and mem_access_unit.
// The requester drives the master modport; the unit drives the slave modport.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// RISC-V byte-addressed load/store front end for a word-addressed registered memory.
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
module mem_access_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mem_access_unit_if.slave  req_if,
  output logic              mem_rw_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_data_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE,
    LD_ISSUE,
    LD_DATA,
    ST_READ,
    ST_MERGE,
    ST_WRITE,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        funct3Ok;
  logic        misaligned;
  logic        outOfRange;
  logic        reqErr;
  logic [7:0]  byteLane;
  logic [15:0] halfLane;
  logic [31:0] loadData;
  logic [31:0] mergedWord;

  // Request legality is judged on the live bus values at the accept edge.
  always_comb begin
    funct3Ok   = 1'b0;
    misaligned = 1'b0;
    outOfRange = 1'b0;
    if (req_if.req_we) begin
      funct3Ok = req_if.req_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      funct3Ok = req_if.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    if (req_if.req_funct3[1:0] == 2'b01) begin
      misaligned = req_if.req_addr[0];
    end else if (req_if.req_funct3[1:0] == 2'b10) begin
      misaligned = (req_if.req_addr[1:0] != 2'b00);
    end
    outOfRange = ({2'b00, req_if.req_addr[31:2]} >= $unsigned(MEM_WORDS));
    reqErr     = !funct3Ok || misaligned || outOfRange;
  end

  always_comb begin
    byteLane = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    halfLane = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
    unique case (funct3_q)
      3'b000:  loadData = {{24{byteLane[7]}}, byteLane};
      3'b001:  loadData = {{16{halfLane[15]}}, halfLane};
      3'b100:  loadData = {24'h000000, byteLane};
      3'b101:  loadData = {16'h0000, halfLane};
      default: loadData = mem_rdata_i;
    endcase
  end

  // data_q holds the raw store data until ST_MERGE replaces it with the merged word.
  always_comb begin
    mergedWord = mem_rdata_i;
    if (funct3_q[1:0] == 2'b00) begin
      mergedWord[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    end else begin
      mergedWord[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_if.req_valid) begin
          funct3_d = req_if.req_funct3;
          addr_d   = req_if.req_addr;
          if (reqErr) begin
            rdata_d = 32'h0000_0000;
            err_d   = 1'b1;
            state_d = RESP;
          end else if (req_if.req_we) begin
            data_d  = req_if.req_wdata;
            state_d = (req_if.req_funct3 == 3'b010) ? ST_WRITE : ST_READ;
          end else begin
            state_d = LD_ISSUE;
          end
        end
      end
      LD_ISSUE: state_d = LD_DATA;
      LD_DATA: begin
        rdata_d = loadData;
        err_d   = 1'b0;
        state_d = RESP;
      end
      ST_READ: state_d = ST_MERGE;
      ST_MERGE: begin
        data_d  = mergedWord;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        rdata_d = 32'h0000_0000;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0000_0000;
      data_q   <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Write strobe decodes straight from state so reset kills a pending write at once.
  assign mem_rw_o          = (state_q == ST_WRITE);
  assign mem_addr_o        = {2'b00, addr_q[31:2]};
  assign mem_data_o        = data_q;
  assign req_if.req_ready  = (state_q == IDLE);
  assign req_if.rsp_valid  = (state_q == RESP);
  assign req_if.rsp_rdata  = rdata_q;
  assign req_if.rsp_err    = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: table of load/store vectors with a response scoreboard,
// plus hand-written handshake and reset-abort sequences.
module tb_mem_access_unit;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
    int          expWrites;
    logic [31:0] expWaddr;
    logic [31:0] expWdata;
  } vec_t;

  logic        clk;
  logic        rstN;
  logic        memRw;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic [31:0] memRdata;
  logic [31:0] memArr [1024];

  int          checks;
  int          errors;
  int          totalWrites;
  int          startWrites;
  logic [31:0] lastWaddr;
  logic [31:0] lastWdata;
  vec_t        vecs [$];
  vec_t        expQ [$];

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_WORDS(1024)) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .req_if      (bus),
    .mem_rw_o    (memRw),
    .mem_addr_o  (memAddr),
    .mem_data_o  (memData),
    .mem_rdata_i (memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered memory: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (memRw) memArr[memAddr[9:0]] <= memData;
    memRdata <= memArr[memAddr[9:0]];
  end

  always @(negedge clk) begin
    if (memRw) begin
      totalWrites = totalWrites + 1;
      lastWaddr   = memAddr;
      lastWdata   = memData;
    end
  end

  function automatic vec_t mkVec(string name, logic we, logic [2:0] f3, logic [31:0] addr,
                                 logic [31:0] wdata, logic [31:0] expRdata, logic expErr,
                                 int expLat, int expWrites, logic [31:0] expWaddr,
                                 logic [31:0] expWdata);
    vec_t v;
    v.name = name; v.we = we; v.funct3 = f3; v.addr = addr; v.wdata = wdata;
    v.expRdata = expRdata; v.expErr = expErr; v.expLat = expLat;
    v.expWrites = expWrites; v.expWaddr = expWaddr; v.expWdata = expWdata;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input int lat);
    vec_t v;
    v = expQ.pop_front();
    checkVal({v.name, " rdata"}, bus.rsp_rdata, v.expRdata);
    checkVal({v.name, " err"}, {31'd0, bus.rsp_err}, {31'd0, v.expErr});
    checkVal({v.name, " latency"}, lat, v.expLat);
    checkVal({v.name, " writes"}, totalWrites - startWrites, v.expWrites);
    if (v.expWrites > 0) begin
      checkVal({v.name, " waddr"}, lastWaddr, v.expWaddr);
      checkVal({v.name, " wdata"}, lastWdata, v.expWdata);
    end
  endtask

  // Waits for ready at a negedge, drives the request and returns just after the accept edge.
  task automatic applyStimulus(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL %s ready timeout: got %b expected 1", v.name, bus.req_ready);
    end
    bus.req_we     = v.we;
    bus.req_funct3 = v.funct3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.req_valid  = 1'b1;
    startWrites    = totalWrites;
    expQ.push_back(v);
    @(posedge clk);
  endtask

  task automatic waitResponse(input string name);
    bit seen;
    seen = 0;
    for (int lat = 1; lat <= 8 && !seen; lat++) begin
      @(negedge clk);
      if (lat == 1) bus.req_valid = 1'b0;
      if (bus.rsp_valid) begin
        checkOutput(lat);
        seen = 1;
      end
    end
    if (!seen) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL %s response timeout: got no rsp_valid expected one within 8 cycles", name);
      void'(expQ.pop_front());
    end
  endtask

  initial begin
    vec_t v;
    bit seen;
    checks         = 0;
    errors         = 0;
    totalWrites    = 0;
    startWrites    = 0;
    lastWaddr      = 32'h0;
    lastWdata      = 32'h0;
    rstN           = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    vecs.push_back(mkVec("SW 0x10",     1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0, 2, 1, 32'h4,   32'hDEADBEEF));
    vecs.push_back(mkVec("LW 0x10",     0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0, 3, 0, 32'h0,   32'h0));
    vecs.push_back(mkVec("SB 0x12",     1, 3'b000, 32'h12,   32'h55,       32'h0,        0, 4, 1, 32'h4,   32'hDE55BEEF));
    vecs.push_back(mkVec("LB 0x13",     0, 3'b000, 32'h13,   32'h0,        32'hFFFFFFDE, 0, 3, 0, 32'h0,   32'h0));
    vecs.push_back(mkVec("LBU 0x13",    0, 3'b100, 32'h13,   32'h0,        32'h000000DE, 0, 3, 0, 32'h0,   32'h0));
    vecs.push_back(mkVec("SH 0x10",     1, 3'b001, 32'h10,   32'h1234ABCD, 32'h0,        0, 4, 1, 32'h4,   32'hDE55ABCD));
    vecs.push_back(mkVec("LH 0x10",     0, 3'b001, 32'h10,   32'h0,        32'hFFFFABCD, 0, 3, 0, 32'h0,   32'h0));
    vecs.push_back(mkVec("LHU 0x12",    0, 3'b101, 32'h12,   32'h0,        32'h0000DE55, 0, 3, 0, 32'h0,   32'h0));
    vecs.push_back(mkVec("err LW 0x11", 0, 3'b010, 32'h11,   32'h0,        32'h0,        1, 1, 0, 32'h0,   32'h0));
    vecs.push_back(mkVec("err SH 0x13", 1, 3'b001, 32'h13,   32'h99999999, 32'h0,        1, 1, 0, 32'h0,   32'h0));
    vecs.push_back(mkVec("err LH 0x11", 0, 3'b001, 32'h11,   32'h0,        32'h0,        1, 1, 0, 32'h0,   32'h0));
    vecs.push_back(mkVec("err ld f011", 0, 3'b011, 32'h10,   32'h0,        32'h0,        1, 1, 0, 32'h0,   32'h0));
    vecs.push_back(mkVec("err st f100", 1, 3'b100, 32'h10,   32'h11111111, 32'h0,        1, 1, 0, 32'h0,   32'h0));
    vecs.push_back(mkVec("err LW range",0, 3'b010, 32'h1000, 32'h0,        32'h0,        1, 1, 0, 32'h0,   32'h0));
    vecs.push_back(mkVec("LW 0x10 kept",0, 3'b010, 32'h10,   32'h0,        32'hDE55ABCD, 0, 3, 0, 32'h0,   32'h0));
    vecs.push_back(mkVec("SB 0x10",     1, 3'b000, 32'h10,   32'hFFFFFF80, 32'h0,        0, 4, 1, 32'h4,   32'hDE55AB80));
    vecs.push_back(mkVec("LB 0x10",     0, 3'b000, 32'h10,   32'h0,        32'hFFFFFF80, 0, 3, 0, 32'h0,   32'h0));
    vecs.push_back(mkVec("LBU 0x11",    0, 3'b100, 32'h11,   32'h0,        32'h000000AB, 0, 3, 0, 32'h0,   32'h0));
    vecs.push_back(mkVec("SW 0xFFC",    1, 3'b010, 32'hFFC,  32'h0F0F1234, 32'h0,        0, 2, 1, 32'h3FF, 32'h0F0F1234));
    vecs.push_back(mkVec("LH 0xFFE",    0, 3'b001, 32'hFFE,  32'h0,        32'h00000F0F, 0, 3, 0, 32'h0,   32'h0));
    vecs.push_back(mkVec("LHU 0xFFC",   0, 3'b101, 32'hFFC,  32'h0,        32'h00001234, 0, 3, 0, 32'h0,   32'h0));
    vecs.push_back(mkVec("SW 0x14",     1, 3'b010, 32'h14,   32'h01020304, 32'h0,        0, 2, 1, 32'h5,   32'h01020304));
    vecs.push_back(mkVec("SW 0x20",     1, 3'b010, 32'h20,   32'h11112222, 32'h0,        0, 2, 1, 32'h8,   32'h11112222));

    repeat (3) @(negedge clk);
    checkVal("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'h0);
    checkVal("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    checkVal("reset rsp_err", {31'd0, bus.rsp_err}, 32'h0);
    checkVal("reset mem_rw", {31'd0, memRw}, 32'h0);
    checkVal("reset mem_addr", memAddr, 32'h0);
    checkVal("reset mem_data", memData, 32'h0);
    checkVal("reset req_ready", {31'd0, bus.req_ready}, 32'h1);
    rstN = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      waitResponse(vecs[i].name);
    end

    // Busy SB with valid held high and the bus churning underneath it.
    v = mkVec("hold SB 0x14", 1, 3'b000, 32'h14, 32'h000000AA, 32'h0, 0, 4, 1, 32'h5, 32'h010203AA);
    applyStimulus(v);
    seen = 0;
    for (int lat = 1; lat <= 8 && !seen; lat++) begin
      @(negedge clk);
      checkVal("hold ready low", {31'd0, bus.req_ready}, 32'h0);
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h18 + 32'(lat * 4);
      bus.req_wdata  = $urandom;
      if (bus.rsp_valid) begin
        checkOutput(lat);
        seen = 1;
      end
    end
    if (!seen) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL hold response timeout: got no rsp_valid expected one within 8 cycles");
      void'(expQ.pop_front());
    end
    @(negedge clk);
    checkVal("hold ready after resp", {31'd0, bus.req_ready}, 32'h1);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkVal("hold no re-accept", {31'd0, bus.req_ready}, 32'h1);
    v = mkVec("LW 0x14 after hold", 0, 3'b010, 32'h14, 32'h0, 32'h010203AA, 0, 3, 0, 32'h0, 32'h0);
    applyStimulus(v);
    waitResponse(v.name);

    // Reset lands during ST_WRITE; the pending write must never reach memory.
    @(negedge clk);
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'hCAFEF00D;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkVal("abort write active", {31'd0, memRw}, 32'h1);
    #1 rstN = 1'b0;
    #1;
    checkVal("abort mem_rw", {31'd0, memRw}, 32'h0);
    checkVal("abort mem_addr", memAddr, 32'h0);
    checkVal("abort mem_data", memData, 32'h0);
    checkVal("abort rsp_rdata", bus.rsp_rdata, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkVal("abort no rsp_valid", {31'd0, bus.rsp_valid}, 32'h0);
    end
    rstN = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkVal("post abort no rsp_valid", {31'd0, bus.rsp_valid}, 32'h0);
    end
    v = mkVec("LW 0x20 after abort", 0, 3'b010, 32'h20, 32'h0, 32'h11112222, 0, 3, 0, 32'h0, 32'h0);
    applyStimulus(v);
    waitResponse(v.name);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
